// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier.
//   Radix-2 shift-and-add over the 24-bit significands (24 iterations),
//   one normalise step, result truncated. Start/finish handshake and the
//   zero/inf/NaN handling match the FP divider, so the two blocks can sit
//   behind the same FPU operation mux.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   en     - start request, sampled only in IDLE
//   inA    - multiplicand (IEEE-754 single)
//   inB    - multiplier   (IEEE-754 single)
//   out    - product, valid while finish=1, held until the next load
//   finish - one-cycle completion pulse
//   busy   - high in MUL/NORM/DONE, en ignored while high
module fp_mul_seq #(
  parameter logic [31:0] NAN_PATTERN = 32'h7FD55555
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic [31:0] out,
  output logic        finish,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } cls_t;

  // Denormals are flushed: a zero exponent means zero whatever the mantissa.
  function automatic cls_t classify(input logic [31:0] x);
    cls_t c;
    c.zero = (x[30:23] == 8'h00);
    c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    return c;
  endfunction

  state_t      state, state_n;
  cls_t        ca, cb;
  logic        special;
  logic        sign_in;
  logic [31:0] special_res;

  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic [47:0] mcand;      // multiplicand, pre-shifted left once per iteration
  logic [23:0] mplier;     // multiplier, consumed LSB first
  logic [47:0] acc;
  logic [4:0]  cnt;

  logic signed [9:0] e_norm;
  logic [22:0]       m_norm;
  logic [31:0]       norm_res;

  assign ca      = classify(inA);
  assign cb      = classify(inB);
  assign special = ca.zero | ca.inf | ca.nan | cb.zero | cb.inf | cb.nan;
  assign sign_in = inA[31] ^ inB[31];

  always_comb begin
    special_res = {sign_in, 31'h0};
    if (ca.nan || cb.nan || (ca.zero && cb.inf) || (ca.inf && cb.zero))
      special_res = NAN_PATTERN;
    else if (ca.inf || cb.inf)
      special_res = {sign_in, 8'hFF, 23'h0};
  end

  // Normalise the finished 48-bit product; the exponent is kept 10-bit
  // signed so both overflow and underflow remain visible.
  always_comb begin
    e_norm = {2'b00, ea_r} + {2'b00, eb_r} - (acc[47] ? 10'd126 : 10'd127);
    m_norm = acc[47] ? acc[46:24] : acc[45:23];
    if (e_norm >= 10'sd255)
      norm_res = {sign_r, 8'hFF, 23'h0};
    else if (e_norm <= 10'sd0)
      norm_res = {sign_r, 31'h0};
    else
      norm_res = {sign_r, e_norm[7:0], m_norm};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (en) state_n = special ? DONE : MUL;
      MUL:  if (cnt == 5'd1) state_n = NORM;
      NORM: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign finish = (state == DONE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= 32'h0;
      sign_r <= 1'b0;
      ea_r   <= 8'h0;
      eb_r   <= 8'h0;
      mcand  <= 48'h0;
      mplier <= 24'h0;
      acc    <= 48'h0;
      cnt    <= 5'd0;
    end else begin
      case (state)
        IDLE: if (en) begin
          if (special) begin
            out <= special_res;
          end else begin
            sign_r <= sign_in;
            ea_r   <= inA[30:23];
            eb_r   <= inB[30:23];
            mcand  <= {24'h0, 1'b1, inA[22:0]};
            mplier <= {1'b1, inB[22:0]};
            acc    <= 48'h0;
            cnt    <= 5'd24;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 5'd1;
        end
        NORM: out <= norm_res;
        default: ;
      endcase
    end
  end

endmodule
